// File: rtl/bf16_addsub_norm.sv
// Post-alignment stage of the bfloat16 adder/subtractor.
// Takes the common exponent and two aligned 11-bit mantissas
// ([10] hidden, [9:3] fraction, [2:0] guard). It performs the effective
// add or subtract, normalizes one bit per cycle, rounds to nearest even,
// and packs a bfloat16 result.
// Handshake: a bundle is accepted on a rising edge where in_valid & in_ready.
// A result is consumed on a rising edge where out_valid & out_ready.
// out_valid and result hold steady until they are consumed.
module bf16_addsub_norm (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic        op,
    input  logic [7:0]  as_exp,
    input  logic [10:0] mantisa_a,
    input  logic [10:0] mantisa_b,
    output logic [15:0] result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf,
    output logic        uf
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sa_q, sa_d;          // sign of a
    logic        sb_q, sb_d;          // effective sign of b (sign_b ^ op)
    logic [7:0]  exp_q, exp_d;        // common exponent from alignment
    logic [10:0] ma_q, ma_d;
    logic [10:0] mb_q, mb_d;
    logic        sign_q, sign_d;      // sign of the result
    logic [11:0] m_q, m_d;            // working mantissa, [11] is carry-out
    logic [9:0]  e_q, e_d;            // working exponent with headroom
    logic [15:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        uf_q, uf_d;

    // Add/subtract datapath
    logic        a_ge_b;
    logic [11:0] mag_sum;
    logic [11:0] mag_diff;
    logic [11:0] add_m;
    logic        add_sign;

    // Rounding datapath. The hidden bit is always set on entry to ROUND.
    // For that reason a carry out of the 7-bit fraction is the mantissa carry.
    logic        rnd_inc;
    logic [7:0]  rnd_frac;
    logic [9:0]  rnd_e;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign uf        = uf_q;

    // Effective add or subtract on the registered operand magnitudes
    always_comb begin
        a_ge_b   = (ma_q >= mb_q);
        mag_sum  = {1'b0, ma_q} + {1'b0, mb_q};
        mag_diff = a_ge_b ? ({1'b0, ma_q} - {1'b0, mb_q})
                          : ({1'b0, mb_q} - {1'b0, ma_q});
        if (sa_q == sb_q) begin
            add_m    = mag_sum;
            add_sign = sa_q;
        end else begin
            add_m    = mag_diff;
            add_sign = a_ge_b ? sa_q : sb_q;
        end
    end

    // Round-to-nearest-even increment, with the exponent bump on mantissa carry
    always_comb begin
        rnd_inc  = m_q[2] & ((|m_q[1:0]) | m_q[3]);
        rnd_frac = {1'b0, m_q[9:3]} + {7'd0, rnd_inc};
        rnd_e    = e_q + {9'd0, rnd_frac[7]};
    end

    // Next-state and datapath updates for the operation sequence
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        exp_d    = exp_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        sign_d   = sign_q;
        m_d      = m_q;
        e_d      = e_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        uf_d     = uf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sa_d    = sign_a;
                    sb_d    = sign_b ^ op;
                    exp_d   = as_exp;
                    ma_d    = mantisa_a;
                    mb_d    = mantisa_b;
                    ovf_d   = 1'b0;
                    uf_d    = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (add_m == 12'd0) begin
                    // Exact cancellation gives -0 only when both operands are negative
                    result_d = {sa_q & sb_q, 15'h0000};
                    state_d  = S_DONE;
                end else begin
                    m_d     = add_m;
                    sign_d  = add_sign;
                    e_d     = {2'b00, exp_q};
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (m_q[11]) begin
                    // Carry-out: shift right, and keep the lost bit as a sticky bit
                    m_d     = {1'b0, m_q[11:2], m_q[1] | m_q[0]};
                    e_d     = e_q + 10'd1;
                    state_d = S_ROUND;
                end else if (m_q[10]) begin
                    state_d = S_ROUND;
                end else if (e_q <= 10'd1) begin
                    // The exponent cannot go lower, so flush to signed zero
                    result_d = {sign_q, 15'h0000};
                    uf_d     = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    m_d = {m_q[10:0], 1'b0};
                    e_d = e_q - 10'd1;
                end
            end
            S_ROUND: begin
                if (rnd_e >= 10'd255) begin
                    result_d = {sign_q, 8'hFF, 7'h00};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_e[7:0], rnd_frac[6:0]};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            exp_q    <= 8'h00;
            ma_q     <= 11'h000;
            mb_q     <= 11'h000;
            sign_q   <= 1'b0;
            m_q      <= 12'h000;
            e_q      <= 10'h000;
            result_q <= 16'h0000;
            ovf_q    <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            exp_q    <= exp_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            sign_q   <= sign_d;
            m_q      <= m_d;
            e_q      <= e_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            uf_q     <= uf_d;
        end
    end

endmodule

// File: tb/tb_bf16_addsub_norm.sv
// Directed bench for bf16_addsub_norm.
// Each vector carries a hand-computed result, flags and latency.
module tb_bf16_addsub_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_a;
  logic        sign_b;
  logic        op;
  logic [7:0]  as_exp;
  logic [10:0] mantisa_a;
  logic [10:0] mantisa_b;
  logic [15:0] result;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        uf;

  int checks = 0;
  int errors = 0;

  bf16_addsub_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .op        (op),
    .as_exp    (as_exp),
    .mantisa_a (mantisa_a),
    .mantisa_b (mantisa_b),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .uf        (uf)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one bundle and return just after the accept edge
  task automatic start_op(input string tag, input logic sa, input logic sb, input logic o,
                          input logic [7:0] e, input logic [10:0] a, input logic [10:0] b);
    @(negedge clk);
    sign_a    = sa;
    sign_b    = sb;
    op        = o;
    as_exp    = e;
    mantisa_a = a;
    mantisa_b = b;
    in_valid  = 1'b1;
    check_val({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then check latency, result and flags
  task automatic wait_result(input string tag, input int lat, input logic [15:0] res,
                             input logic ov, input logic u);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 30);
    check_val({tag, ".latency"}, 32'(n), 32'(lat));
    check_val({tag, ".result"}, 32'(result), 32'(res));
    check_val({tag, ".ovf"}, 32'(ovf), 32'(ov));
    check_val({tag, ".uf"}, 32'(uf), 32'(u));
    check_val({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  // With out_ready high, the DONE handshake happens on the next edge
  task automatic finish_hs(input string tag);
    @(posedge clk);
    #1;
    check_val({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    check_val({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic sa, input logic sb, input logic o,
                        input logic [7:0] e, input logic [10:0] a, input logic [10:0] b,
                        input int lat, input logic [15:0] res, input logic ov, input logic u);
    start_op(tag, sa, sb, o, e, a, b);
    wait_result(tag, lat, res, ov, u);
    finish_hs(tag);
  endtask

  initial begin
    // reset
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign_a    = 1'b0;
    sign_b    = 1'b0;
    op        = 1'b0;
    as_exp    = 8'h00;
    mantisa_a = 11'h000;
    mantisa_b = 11'h000;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.result", 32'(result), 32'h0000);
    check_val("reset.out_valid", 32'(out_valid), 32'd0);
    check_val("reset.in_ready", 32'(in_ready), 32'd1);
    check_val("reset.ovf", 32'(ovf), 32'd0);
    check_val("reset.uf", 32'(uf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // main function
    run_op("one_plus_one",   1'b0, 1'b0, 1'b0, 8'h7F, 11'h400, 11'h400, 3, 16'h4000, 1'b0, 1'b0);
    run_op("one_minus_one",  1'b0, 1'b0, 1'b1, 8'h7F, 11'h400, 11'h400, 1, 16'h0000, 1'b0, 1'b0);
    run_op("neg_zero",       1'b1, 1'b1, 1'b0, 8'h7F, 11'h000, 11'h000, 1, 16'h8000, 1'b0, 1'b0);
    run_op("1p5_minus_1",    1'b0, 1'b0, 1'b1, 8'h7F, 11'h600, 11'h400, 4, 16'h3F00, 1'b0, 1'b0);
    run_op("1_minus_1p5",    1'b0, 1'b0, 1'b1, 8'h7F, 11'h400, 11'h600, 4, 16'hBF00, 1'b0, 1'b0);
    run_op("round_carry",    1'b0, 1'b0, 1'b0, 8'h7F, 11'h7FC, 11'h000, 3, 16'h4000, 1'b0, 1'b0);
    run_op("round_tie_even", 1'b0, 1'b0, 1'b0, 8'h7F, 11'h7F4, 11'h000, 3, 16'h3FFE, 1'b0, 1'b0);
    run_op("ten_shifts",     1'b0, 1'b0, 1'b1, 8'h7F, 11'h401, 11'h400, 13, 16'h3A80, 1'b0, 1'b0);
    run_op("underflow",      1'b0, 1'b0, 1'b1, 8'h01, 11'h401, 11'h400, 2, 16'h0000, 1'b0, 1'b1);
    run_op("overflow",       1'b0, 1'b0, 1'b0, 8'hFE, 11'h400, 11'h400, 3, 16'h7F80, 1'b1, 1'b0);

    // back-pressure in DONE
    @(negedge clk);
    out_ready = 1'b0;
    start_op("hold", 1'b0, 1'b0, 1'b1, 8'h7F, 11'h600, 11'h400);
    wait_result("hold", 4, 16'h3F00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("hold.out_valid", 32'(out_valid), 32'd1);
      check_val("hold.result", 32'(result), 32'h3F00);
      check_val("hold.in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    finish_hs("hold");

    // overflow again so result and ovf are non-zero before the reset test
    run_op("overflow2", 1'b1, 1'b1, 1'b0, 8'hFE, 11'h400, 11'h400, 3, 16'hFF80, 1'b1, 1'b0);

    // asynchronous reset in the middle of the left-shift loop
    start_op("mid_reset", 1'b0, 1'b0, 1'b1, 8'h7F, 11'h401, 11'h400);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_reset.result", 32'(result), 32'h0000);
    check_val("mid_reset.out_valid", 32'(out_valid), 32'd0);
    check_val("mid_reset.in_ready", 32'(in_ready), 32'd1);
    check_val("mid_reset.ovf", 32'(ovf), 32'd0);
    check_val("mid_reset.uf", 32'(uf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_reset", 1'b0, 1'b0, 1'b0, 8'h7F, 11'h400, 11'h400, 3, 16'h4000, 1'b0, 1'b0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
